// File: rtl/iccm_arb_pkg.sv
// Shared types for the ICCM boot arbiter:
// FSM state encoding and the SRAM request bundle.
package iccm_arb_pkg;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    RUN   = 3'd3,
    HALT  = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } mem_req_t;

  function automatic mem_req_t ldr_wr(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] wdata
  );
    mem_req_t r;
    r.req   = 1'b1;
    r.we    = 1'b1;
    r.addr  = addr;
    r.wdata = wdata;
    r.wmask = '1;
    return r;
  endfunction

endpackage

// File: rtl/iccm_boot_arbiter_if.sv
// SRAM-style request bus (req/we/addr/wdata/wmask).
// The master drives the request; the slave consumes it.
interface iccm_boot_arbiter_if
  import iccm_arb_pkg::*;
#(
  parameter int unsigned Aw = AW,
  parameter int unsigned Dw = DW
);
  logic          req;
  logic          we;
  logic [Aw-1:0] addr;
  logic [Dw-1:0] wdata;
  logic [Dw-1:0] wmask;

  modport master (output req, we, addr, wdata, wmask);
  modport slave  (input  req, we, addr, wdata, wmask);
endinterface

// File: rtl/iccm_arb_skid.sv
// One-entry holding register for a loader write that could
// not reach the SRAM port in the cycle it arrived.
module iccm_arb_skid #(
  parameter int unsigned Aw = 12,
  parameter int unsigned Dw = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [Aw-1:0]         i_addr,
  input  logic [Dw-1:0]         i_wdata,
  iccm_boot_arbiter_if.master   o_wr
);
  logic          r_valid;
  logic [Aw-1:0] r_addr;
  logic [Dw-1:0] r_wdata;

  // A load in the same cycle as a clear refills the entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_wr.req   = r_valid;
  assign o_wr.we    = r_valid;
  assign o_wr.addr  = r_addr;
  assign o_wr.wdata = r_wdata;
  assign o_wr.wmask = '1;
endmodule

// File: rtl/iccm_boot_arbiter.sv
// Shares the ICCM SRAM port between the UART loader and
// core fetch, and holds the core in reset while loading.
module iccm_boot_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int unsigned Aw       = AW,
  parameter int unsigned Dw       = DW,
  parameter logic        BootWait = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          boot_sel_i,
  input  logic          ldr_we_i,
  input  logic [Aw-1:0] ldr_addr_i,
  input  logic [Dw-1:0] ldr_wdata_i,
  input  logic          ldr_done_i,
  input  logic          fetch_req_i,
  input  logic          fetch_we_i,
  input  logic [Aw-1:0] fetch_addr_i,
  input  logic [Dw-1:0] fetch_wdata_i,
  input  logic [Dw-1:0] fetch_wmask_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [Dw-1:0] fetch_rdata_o,
  output logic [1:0]    fetch_rerror_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [Aw-1:0] mem_addr_o,
  output logic [Dw-1:0] mem_wdata_o,
  output logic [Dw-1:0] mem_wmask_o,
  input  logic [Dw-1:0] mem_rdata_i,
  output logic          core_rst_o,
  output logic [2:0]    state_o,
  output logic [Aw:0]   load_cnt_o
);
  localparam logic [Aw:0] CntMax = {1'b1, {Aw{1'b0}}};

  arb_state_e  r_state, w_next;
  logic        r_rd_pend;
  logic [Aw:0] r_cnt;
  logic        w_inc, w_clr, w_sk_load, w_sk_clear;
  logic        w_core_rst, w_gnt;
  mem_req_t    w_mem, w_sk_req, w_fetch;

  iccm_boot_arbiter_if #(.Aw(Aw), .Dw(Dw)) w_skid ();

  iccm_arb_skid #(.Aw(Aw), .Dw(Dw)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_sk_load),
    .i_clear (w_sk_clear),
    .i_addr  (ldr_addr_i),
    .i_wdata (ldr_wdata_i),
    .o_wr    (w_skid)
  );

  assign w_sk_req = '{req: w_skid.req, we: w_skid.we,
                      addr: w_skid.addr, wdata: w_skid.wdata,
                      wmask: w_skid.wmask};
  assign w_fetch  = '{req: fetch_req_i, we: fetch_we_i,
                      addr: fetch_addr_i, wdata: fetch_wdata_i,
                      wmask: fetch_wmask_i};

  always_comb begin
    w_next     = r_state;
    w_mem      = '0;
    w_gnt      = 1'b0;
    w_core_rst = 1'b1;
    w_inc      = 1'b0;
    w_clr      = 1'b0;
    w_sk_load  = 1'b0;
    w_sk_clear = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_next = boot_sel_i ? LOAD : RUN;
        w_clr  = boot_sel_i;
      end
      LOAD, DRAIN: begin
        // A held write goes first; a live one then waits in the skid.
        if (w_skid.req) begin
          w_mem      = w_sk_req;
          w_inc      = 1'b1;
          w_sk_clear = 1'b1;
          w_sk_load  = ldr_we_i;
        end else if (ldr_we_i) begin
          w_mem = ldr_wr(ldr_addr_i, ldr_wdata_i);
          w_inc = 1'b1;
        end
        if (r_state == LOAD) begin
          if (ldr_done_i) w_next = DRAIN;
        end else begin
          w_next = (w_skid.req || ldr_we_i) ? LOAD : RUN;
        end
      end
      RUN: begin
        w_core_rst = 1'b0;
        w_mem      = w_fetch;
        w_gnt      = fetch_req_i;
        if (ldr_we_i) begin
          w_sk_load = 1'b1;
          w_next    = HALT;
        end
      end
      HALT: begin
        w_sk_load = ldr_we_i;
        if (!r_rd_pend) begin
          w_next = LOAD;
          w_clr  = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_rd_pend <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= (r_state == RUN) && fetch_req_i && !fetch_we_i;
      if (w_clr)
        r_cnt <= '0;
      else if (w_inc && r_cnt != CntMax)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mem_req_o      = w_mem.req;
  assign mem_we_o       = w_mem.we;
  assign mem_addr_o     = w_mem.addr;
  assign mem_wdata_o    = w_mem.wdata;
  assign mem_wmask_o    = w_mem.wmask;
  assign fetch_gnt_o    = w_gnt;
  assign fetch_rvalid_o = r_rd_pend;
  assign fetch_rdata_o  = r_rd_pend ? mem_rdata_i : '0;
  assign fetch_rerror_o = 2'b00;
  assign core_rst_o     = w_core_rst;
  assign state_o        = r_state;
  assign load_cnt_o     = r_cnt;
endmodule

// File: tb/tb_iccm_boot_arbiter.sv
// Scoreboard bench for iccm_boot_arbiter: expected SRAM
// requests and read responses are queued and popped by a monitor.
module tb_iccm_boot_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        boot_sel;
  logic        ldr_we, ldr_done;
  logic [11:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic [1:0]  rerror;
  logic        mreq, mwe;
  logic [11:0] maddr;
  logic [31:0] mwdata, mwmask;
  logic [31:0] mrdata;
  logic        core_rst;
  logic [2:0]  state;
  logic [12:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] rq[$];
  logic [31:0] sram [0:4095];

  iccm_boot_arbiter_if #(.Aw(12), .Dw(32)) fif ();

  always #5 clk = ~clk;

  iccm_boot_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .boot_sel_i     (boot_sel),
    .ldr_we_i       (ldr_we),
    .ldr_addr_i     (ldr_addr),
    .ldr_wdata_i    (ldr_wdata),
    .ldr_done_i     (ldr_done),
    .fetch_req_i    (fif.req),
    .fetch_we_i     (fif.we),
    .fetch_addr_i   (fif.addr),
    .fetch_wdata_i  (fif.wdata),
    .fetch_wmask_i  (fif.wmask),
    .fetch_gnt_o    (gnt),
    .fetch_rvalid_o (rvalid),
    .fetch_rdata_o  (rdata),
    .fetch_rerror_o (rerror),
    .mem_req_o      (mreq),
    .mem_we_o       (mwe),
    .mem_addr_o     (maddr),
    .mem_wdata_o    (mwdata),
    .mem_wmask_o    (mwmask),
    .mem_rdata_i    (mrdata),
    .core_rst_o     (core_rst),
    .state_o        (state),
    .load_cnt_o     (cnt)
  );

  // SRAM model: masked write, 1-cycle read latency
  always @(posedge clk) begin
    if (mreq) begin
      if (mwe)
        sram[maddr] <= (sram[maddr] & ~mwmask) | (mwdata & mwmask);
      else
        mrdata <= sram[maddr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mreq) begin
        if (mq.size() == 0) begin
          n_chk++;
          $display("FAIL mem_unexpected: got req addr %0h expected none",
                   maddr);
        end else begin
          exp_t e;
          e = mq.pop_front();
          chk("mem_we", 64'(mwe), 64'(e.we));
          chk("mem_addr", 64'(maddr), 64'(e.addr));
          chk("mem_wdata", 64'(mwdata), 64'(e.wdata));
          chk("mem_wmask", 64'(mwmask), 64'(e.wmask));
        end
      end
      if (rvalid) begin
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL rvalid_unexpected: got rdata %0h expected none",
                   rdata);
        end else begin
          chk("fetch_rdata", 64'(rdata), 64'(rq.pop_front()));
        end
      end
      chk("rerror", 64'(rerror), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lwr(input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    ldr_we    = 1'b1;
    ldr_addr  = a;
    ldr_wdata = d;
    e = '{we: 1'b1, addr: a, wdata: d, wmask: 32'hFFFF_FFFF};
    mq.push_back(e);
  endtask

  task automatic frd(input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    fif.req   = 1'b1;
    fif.we    = 1'b0;
    fif.addr  = a;
    fif.wdata = '0;
    fif.wmask = 32'hFFFF_FFFF;
    e = '{we: 1'b0, addr: a, wdata: 32'h0, wmask: 32'hFFFF_FFFF};
    mq.push_back(e);
    rq.push_back(d);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_mem"}, {mreq, mwe, maddr, mwdata}, 64'd0);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_rvalid"}, {rvalid, rdata}, 64'd0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; boot_sel = 1'b1;
    ldr_we = 1'b0; ldr_done = 1'b0;
    ldr_addr = '0; ldr_wdata = '0;
    fif.req = 1'b1; fif.we = 1'b0; fif.addr = '0;
    fif.wdata = '0; fif.wmask = '1;
    repeat (2) step();
    @(negedge clk);
    chk_reset("rst");

    // boot wait with fetch held requesting
    step(); rst = 1'b0;
    @(negedge clk); chk("idle_state", 64'(state), 64'd0);
    step(); lwr(12'h000, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("load_state", 64'(state), 64'd1);
    chk("load_core_rst", 64'(core_rst), 64'd1);
    chk("load_gnt", 64'(gnt), 64'd0);
    step(); lwr(12'h001, 32'h0000_0013);
    step(); lwr(12'h002, 32'h0000_006F);
    @(negedge clk); chk("load_gnt2", 64'(gnt), 64'd0);
    step(); ldr_we = 1'b0; ldr_done = 1'b1;
    @(negedge clk);
    chk("load_cnt3", 64'(cnt), 64'd3);
    chk("load_rvalid", 64'(rvalid), 64'd0);
    step(); ldr_done = 1'b0; fif.req = 1'b0;
    @(negedge clk);
    chk("drain_state", 64'(state), 64'd2);
    chk("drain_core_rst", 64'(core_rst), 64'd1);

    // fetch after load, plus a masked fetch write
    step(); frd(12'h000, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("run_state", 64'(state), 64'd3);
    chk("run_core_rst", 64'(core_rst), 64'd0);
    chk("run_gnt", 64'(gnt), 64'd1);
    step(); frd(12'h001, 32'h0000_0013);
    step();
    fif.req = 1'b1; fif.we = 1'b1; fif.addr = 12'h003;
    fif.wdata = 32'h0000_AA55; fif.wmask = 32'h0000_FFFF;
    e = '{we: 1'b1, addr: 12'h003, wdata: 32'h0000_AA55,
          wmask: 32'h0000_FFFF};
    mq.push_back(e);
    @(negedge clk); chk("run_wr_gnt", 64'(gnt), 64'd1);

    // run-time reload colliding with a read
    step();
    frd(12'h002, 32'h0000_006F);
    ldr_we = 1'b1; ldr_addr = 12'h010; ldr_wdata = 32'h1234_5678;
    @(negedge clk); chk("reload_gnt", 64'(gnt), 64'd1);
    step(); fif.req = 1'b0; ldr_we = 1'b0;
    e = '{we: 1'b1, addr: 12'h010, wdata: 32'h1234_5678,
          wmask: 32'hFFFF_FFFF};
    mq.push_back(e);
    @(negedge clk);
    chk("halt_state", 64'(state), 64'd4);
    chk("halt_core_rst", 64'(core_rst), 64'd1);
    chk("halt_gnt", 64'(gnt), 64'd0);
    step();
    @(negedge clk); chk("halt_state2", 64'(state), 64'd4);
    step();
    @(negedge clk);
    chk("reload_state", 64'(state), 64'd1);
    chk("reload_cnt0", 64'(cnt), 64'd0);
    step(); lwr(12'h020, 32'h0000_0001);
    @(negedge clk); chk("reload_cnt1", 64'(cnt), 64'd1);
    step(); lwr(12'h021, 32'h0000_0002);

    // async reset mid-LOAD
    step(); ldr_we = 1'b0;
    chk("pre_rst_cnt", 64'(cnt), 64'd3);
    #2 rst = 1'b1;
    #1 chk_reset("async");

    // direct run
    boot_sel = 1'b0;
    step(); step(); rst = 1'b0;
    @(negedge clk); chk("direct_idle", 64'(state), 64'd0);
    step();
    @(negedge clk);
    chk("direct_state", 64'(state), 64'd3);
    chk("direct_core_rst", 64'(core_rst), 64'd0);
    chk("direct_cnt", 64'(cnt), 64'd0);
    repeat (2) step();
    chk("mem_queue_empty", 64'(mq.size()), 64'd0);
    chk("rdata_queue_empty", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
